// File: rtl/uart_tx_top_pkg.sv
// Shared definitions for the UART transmitter: FSM states, output-mux selects
// and serial line levels.
package uart_tx_top_pkg;

   localparam int unsigned MUX_SEL_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam logic [MUX_SEL_W-1:0] SEL_IDLE   = 3'd0;
   localparam logic [MUX_SEL_W-1:0] SEL_START  = 3'd1;
   localparam logic [MUX_SEL_W-1:0] SEL_DATA   = 3'd2;
   localparam logic [MUX_SEL_W-1:0] SEL_PARITY = 3'd3;
   localparam logic [MUX_SEL_W-1:0] SEL_STOP   = 3'd4;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_fsm.sv
// Frame sequencer: state register and data-bit counter. Select, load and shift
// are produced for the state being entered so the top can register the line.
module uart_tx_fsm
   import uart_tx_top_pkg::*;
#(
   parameter int unsigned dataWidth    = 8,
   parameter int unsigned counterWidth = 3,
   parameter int unsigned muxSelWidth  = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid,
   input  logic                   i_par_en,
   output logic [muxSelWidth-1:0] o_sel_c,
   output logic                   o_load_c,
   output logic                   o_shift_c,
   output logic                   o_busy
);

   localparam logic [counterWidth-1:0] LAST_BIT = counterWidth'(dataWidth - 1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [counterWidth-1:0] r_cnt;
   logic [counterWidth-1:0] w_cnt_nxt;
   logic                    w_busy_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         o_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         o_busy  <= w_busy_nxt;
      end
   end

   // Decode the next state and the line source it will present.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_busy_nxt  = 1'b0;
      o_sel_c     = muxSelWidth'(SEL_IDLE);
      o_load_c    = 1'b0;
      o_shift_c   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (i_valid) begin
               w_state_nxt = ST_START;
               w_busy_nxt  = 1'b1;
               o_sel_c     = muxSelWidth'(SEL_START);
               o_load_c    = 1'b1;
            end
         end
         ST_START: begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b1;
            o_sel_c     = muxSelWidth'(SEL_DATA);
            o_shift_c   = 1'b1;
         end
         ST_DATA: begin
            w_busy_nxt = 1'b1;
            if (r_cnt == LAST_BIT) begin
               if (i_par_en) begin
                  w_state_nxt = ST_PARITY;
                  o_sel_c     = muxSelWidth'(SEL_PARITY);
               end else begin
                  w_state_nxt = ST_STOP;
                  o_sel_c     = muxSelWidth'(SEL_STOP);
               end
            end else begin
               w_cnt_nxt = r_cnt + counterWidth'(1);
               o_sel_c   = muxSelWidth'(SEL_DATA);
               o_shift_c = 1'b1;
            end
         end
         ST_PARITY: begin
            w_state_nxt = ST_STOP;
            w_busy_nxt  = 1'b1;
            o_sel_c     = muxSelWidth'(SEL_STOP);
         end
         ST_STOP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: one bit per clock, start / data LSB-first / optional
// parity / stop. Holds the frame word, parity bit and the registered line.
module uart_tx_top
   import uart_tx_top_pkg::*;
#(
   parameter int unsigned dataWidth    = 8,
   parameter int unsigned counterWidth = 3,
   parameter int unsigned muxSelWidth  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [dataWidth-1:0] p_data,
   input  logic                 data_valid,
   input  logic                 par_en,
   input  logic                 par_type,
   output logic                 tx_out,
   output logic                 busy
);

   logic [dataWidth-1:0]   r_data;
   logic                   r_par;
   logic                   r_par_en;
   logic [muxSelWidth-1:0] w_sel;
   logic                   w_load;
   logic                   w_shift;
   logic                   w_tx_nxt;

   uart_tx_fsm #(
      .dataWidth    (dataWidth),
      .counterWidth (counterWidth),
      .muxSelWidth  (muxSelWidth)
   ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (data_valid),
      .i_par_en  (r_par_en),
      .o_sel_c   (w_sel),
      .o_load_c  (w_load),
      .o_shift_c (w_shift),
      .o_busy    (busy)
   );

   // Frame word is captured on acceptance and shifted right as bits go out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data   <= '0;
         r_par    <= 1'b0;
         r_par_en <= 1'b0;
      end else if (w_load) begin
         r_data   <= p_data;
         r_par    <= (^p_data) ^ par_type;
         r_par_en <= par_en;
      end else if (w_shift) begin
         r_data   <= r_data >> 1;
      end
   end

   always_comb begin
      w_tx_nxt = IDLE_LVL;
      case (w_sel)
         muxSelWidth'(SEL_START):  w_tx_nxt = START_BIT;
         muxSelWidth'(SEL_DATA):   w_tx_nxt = r_data[0];
         muxSelWidth'(SEL_PARITY): w_tx_nxt = r_par;
         muxSelWidth'(SEL_STOP):   w_tx_nxt = STOP_BIT;
         default:                  w_tx_nxt = IDLE_LVL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_out <= IDLE_LVL;
      end else begin
         tx_out <= w_tx_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_top.sv
// Self-checking bench for uart_tx_top: directed and random frames compared
// cycle by cycle against a frame built from the line protocol.
module tb_uart_tx_top;

   logic       clk        = 1'b0;
   logic       rst        = 1'b0;
   logic [7:0] p_data     = 8'h00;
   logic       data_valid = 1'b0;
   logic       par_en     = 1'b0;
   logic       par_type   = 1'b0;
   logic       tx_out;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   uart_tx_top #(
      .dataWidth    (8),
      .counterWidth (3),
      .muxSelWidth  (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_type   (par_type),
      .tx_out     (tx_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_tx"}, 32'(tx_out), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Reference frame: line level for each busy cycle, in transmission order.
   function automatic int ref_frame(input logic [7:0] d, input logic pen, input logic pt,
                                    output logic [15:0] bits);
      int len;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
      len = 9;
      if (pen) begin
         bits[len] = (^d) ^ pt;
         len++;
      end
      bits[len] = 1'b1;
      return len + 1;
   endfunction

   // Request one frame, then compare line and busy each cycle; inputs are
   // scrambled mid-frame to show they have no effect after acceptance.
   task automatic send(input logic [7:0] d, input logic pen, input logic pt,
                       input int hold, input bit inject, output logic [15:0] cap);
      logic [15:0] exp;
      int          len;
      len        = ref_frame(d, pen, pt, exp);
      cap        = '1;
      p_data     = d;
      par_en     = pen;
      par_type   = pt;
      data_valid = 1'b1;
      tick();
      for (int i = 0; i < len; i++) begin
         data_valid = (i + 1 < hold);
         p_data     = 8'($urandom);
         par_en     = 1'($urandom);
         par_type   = 1'($urandom);
         if (inject && i == 4) begin
            data_valid = 1'b1;
            p_data     = 8'h55;
         end
         if (i == len - 1) data_valid = 1'b0;
         cap[i] = tx_out;
         chk($sformatf("tx_%02h_c%0d", d, i), 32'(tx_out), 32'(exp[i]));
         chk($sformatf("busy_%02h_c%0d", d, i), 32'(busy), 32'd1);
         tick();
      end
      data_valid = 1'b0;
      chk_idle($sformatf("end_%02h", d));
   endtask

   initial begin
      logic [15:0] cap;
      logic [7:0]  d;
      logic        pen;
      logic        pt;

      rst = 1'b0;
      repeat (3) begin tick(); chk_idle("in_reset"); end
      rst = 1'b1;
      repeat (3) begin tick(); chk_idle("post_reset"); end

      send(8'hA5, 1'b1, 1'b0, 1, 1'b0, cap);
      chk("a5_frame", 32'(cap[10:0]), 32'(11'b1_0_10100101_0));

      send(8'h01, 1'b1, 1'b0, 1, 1'b0, cap);
      chk("par_01_even", 32'(cap[9]), 32'd1);
      send(8'h01, 1'b1, 1'b1, 1, 1'b0, cap);
      chk("par_01_odd", 32'(cap[9]), 32'd0);
      send(8'hFF, 1'b1, 1'b0, 1, 1'b0, cap);
      chk("par_ff_even", 32'(cap[9]), 32'd0);

      send(8'h3C, 1'b0, 1'b0, 1, 1'b0, cap);
      chk("3c_noparity_frame", 32'(cap[9:0]), 32'(10'b1_00111100_0));

      send(8'hA5, 1'b1, 1'b0, 1, 1'b1, cap);
      chk("a5_inject_frame", 32'(cap[10:0]), 32'(11'b1_0_10100101_0));
      repeat (4) begin tick(); chk_idle("after_inject"); end

      send(8'h96, 1'b1, 1'b1, 3, 1'b0, cap);
      repeat (3) begin tick(); chk_idle("after_hold"); end

      for (int k = 0; k < 10; k++) begin
         d   = 8'($urandom);
         pen = 1'($urandom);
         pt  = 1'($urandom);
         send(d, pen, pt, 1, 1'b0, cap);
      end

      p_data     = 8'hA5;
      par_en     = 1'b1;
      par_type   = 1'b0;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      repeat (4) tick();
      chk("midframe_busy_before", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      chk_idle("midframe_reset");
      repeat (2) begin tick(); chk_idle("midframe_held"); end
      rst = 1'b1;
      repeat (3) begin tick(); chk_idle("midframe_release"); end

      send(8'h5A, 1'b1, 1'b1, 1, 1'b0, cap);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
